fifo_write_ctrl: RTL and testbench

Write-side pointer and flag controller for the dual-clock FIFO, located directly upstream of `fifo_memory`. It accepts push requests in the `write_clk` domain and drives the memory's `write_addr` and `write_enable` ports. It maintains a binary and a Gray write pointer and synchronises the read-domain Gray pointer into `write_clk`. From these it produces full, almost-full, fill-level and sticky-overflow status, and exports the Gray write pointer for the read-side controller.

---
 rtl/fifo_write_ctrl.sv | 79 +++++++
 tb/tb_fifo_write_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller for the dual-clock FIFO: binary + Gray write
// pointers, read-pointer synchroniser, and full / almost-full / level / overflow status.
module fifo_write_ctrl #(
  parameter int unsigned ADDR_WIDTH        = 3,
  parameter int unsigned ALMOST_FULL_LEVEL = 6,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                  write_clk,
  input  logic                  write_rst_n,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH:0]   read_ptr_gray,
  input  logic                  overflow_clr,
  output logic                  write_enable,
  output logic [ADDR_WIDTH:0]   write_addr,
  output logic [ADDR_WIDTH:0]   write_ptr_gray,
  output logic                  write_full,
  output logic                  write_almost_full,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  write_overflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL   = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] FULL_INV = {2'b11, {(PW-2){1'b0}}};

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0][PW-1:0] rq_q;
  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin_sync;

  assign rsync = rq_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign rbin_sync[i] = ^(rsync >> i);
  end

  // Status is derived only from flops so full and level can never disagree.
  assign write_full        = (wgray_q == (rsync ^ FULL_INV));
  assign write_level       = wbin_q - rbin_sync;
  assign write_almost_full = (write_level >= AF_LVL);
  assign write_enable      = write_req & ~write_full;
  assign write_addr        = wbin_q;
  assign write_ptr_gray    = wgray_q;
  assign write_overflow    = ovf_q;

  always_comb begin
    wbin_d  = wbin_q;
    wgray_d = wgray_q;
    ovf_d   = ovf_q;
    if (write_enable) begin
      wbin_d  = wbin_q + PW'(1);
      wgray_d = wbin_d ^ (wbin_d >> 1);
    end
    // A rejected push beats a simultaneous clear.
    if (write_req && write_full) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      ovf_q   <= 1'b0;
      rq_q    <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      ovf_q   <= ovf_d;
      rq_q    <= {rq_q[SYNC_STAGES-2:0], read_ptr_gray};
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Randomised + directed bench for fifo_write_ctrl against a count-based occupancy model.
module tb_fifo_write_ctrl;

  localparam int S  = 2;
  localparam int AF = 6;

  logic       write_clk = 1'b0;
  logic       write_rst_n;
  logic       write_req;
  logic [3:0] read_ptr_gray;
  logic       overflow_clr;
  logic       write_enable;
  logic [3:0] write_addr;
  logic [3:0] write_ptr_gray;
  logic       write_full;
  logic       write_almost_full;
  logic [3:0] write_level;
  logic       write_overflow;

  fifo_write_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(AF), .SYNC_STAGES(S)) dut (
    .write_clk(write_clk), .write_rst_n(write_rst_n), .write_req(write_req),
    .read_ptr_gray(read_ptr_gray), .overflow_clr(overflow_clr),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_ptr_gray(write_ptr_gray), .write_full(write_full),
    .write_almost_full(write_almost_full), .write_level(write_level),
    .write_overflow(write_overflow)
  );

  always #5 write_clk = ~write_clk;

  // Model: total writes accepted, total reads driven, and the read totals seen per sync stage.
  int   wr_tot;
  int   rd_drv;
  int   sp [S];
  logic ovf_m;
  int   tests;
  int   fails;

  function automatic logic [3:0] gray_of(int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int lvl_m();
    return wr_tot - sp[S-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int l;
    l = lvl_m();
    chk("level",   32'(write_level),       32'(l));
    chk("full",    32'(write_full),        32'(l == 8));
    chk("afull",   32'(write_almost_full), 32'(l >= AF));
    chk("addr",    32'(write_addr),        32'(wr_tot % 16));
    chk("gray",    32'(write_ptr_gray),    32'(gray_of(wr_tot)));
    chk("ovf",     32'(write_overflow),    32'(ovf_m));
    chk("enable",  32'(write_enable),      32'(write_req && (l < 8)));
  endtask

  task automatic model_reset();
    wr_tot = 0;
    rd_drv = 0;
    ovf_m  = 1'b0;
    for (int k = 0; k < S; k++) sp[k] = 0;
  endtask

  // One clock: drive inputs in the low phase, check, take the edge, update model, check.
  task automatic cycle(input logic req, input logic clr);
    logic [3:0] g_prev;
    logic       acc;
    write_req     = req;
    overflow_clr  = clr;
    read_ptr_gray = gray_of(rd_drv);
    #1;
    check_all();
    g_prev = write_ptr_gray;
    acc = req && (lvl_m() < 8);
    @(posedge write_clk);
    if (req && !acc) ovf_m = 1'b1;
    else if (clr)    ovf_m = 1'b0;
    if (acc) wr_tot++;
    for (int k = S - 1; k > 0; k--) sp[k] = sp[k-1];
    sp[0] = rd_drv;
    #1;
    check_all();
    chk("gray_1bit", 32'($countones(write_ptr_gray ^ g_prev)), 32'(acc));
    @(negedge write_clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    write_rst_n   = 1'b0;
    write_req     = 1'b0;
    overflow_clr  = 1'b0;
    read_ptr_gray = 4'h0;
    #2;
    check_all();
    @(negedge write_clk);
    @(negedge write_clk);
    write_rst_n = 1'b1;

    // Fill from empty with no reads.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 5) chk("afull_at6", 32'(write_almost_full), 32'd1);
    end
    chk("full_after8", 32'(write_full), 32'd1);
    chk("gray_after8", 32'(write_ptr_gray), 32'hC);
    chk("level_after8", 32'(write_level), 32'd8);

    // Push while full, then clear the sticky flag.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      chk("addr_hold", 32'(write_addr), 32'd8);
    end
    cycle(1'b0, 1'b1);
    chk("ovf_cleared", 32'(write_overflow), 32'd0);

    // One read: full persists one edge, releases after the second.
    rd_drv = 1;
    cycle(1'b0, 1'b0);
    chk("full_sync1", 32'(write_full), 32'd1);
    cycle(1'b0, 1'b0);
    chk("full_sync2", 32'(write_full), 32'd0);
    chk("level_sync2", 32'(write_level), 32'd7);

    // Wrap-around with matching reads.
    for (int i = 0; i < 20; i++) begin
      if (rd_drv < wr_tot) rd_drv++;
      cycle(1'b1, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if (rd_drv < wr_tot && $urandom_range(0, 2) == 0) rd_drv++;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    // Drain, then build level 5 and reset mid-burst.
    rd_drv = wr_tot;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    chk("level5", 32'(write_level), 32'd5);
    write_req   = 1'b1;
    #2;
    write_rst_n = 1'b0;
    model_reset();
    read_ptr_gray = 4'h0;
    #1;
    check_all();
    chk("rst_addr", 32'(write_addr), 32'd0);
    @(negedge write_clk);
    write_rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    chk("first_after_rst", 32'(write_addr), 32'd1);

    // Level 4, then a push on the same edge a read becomes visible.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    chk("level4", 32'(write_level), 32'd4);
    rd_drv = 1;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("simul_level", 32'(write_level), 32'd4);
    chk("simul_addr", 32'(write_addr), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
